// File: rtl/pipe_control_unit.sv
// Pipelined MIPS32 control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control registers, jump-bubble FSM.
// Optional feature: define LOAD_USE_STALL_EN for the built-in load-use interlock.
module pipe_control_unit #(
  parameter int JUMP_BUBBLES = 1,
  parameter int REG_ADDR_W   = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic [REG_ADDR_W-1:0] rs_id,
  input  logic [REG_ADDR_W-1:0] rt_id,
  output logic                  is_jump,
  output logic [1:0]            branch_src,
  output logic [1:0]            compare_code,
  output logic [2:0]            ex_ctrl,
  output logic [1:0]            mem_ctrl,
  output logic [2:0]            wb_ctrl,
  output logic                  stall_if,
  output logic                  flush_if,
  output logic                  illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_BUBBLE = 1'b1;

  localparam logic [1:0] BUBBLE_LOAD = 2'(JUMP_BUBBLES - 1);

  logic [7:0] idexWord_q, idexWord_d;
  logic [4:0] exmemWord_q, exmemWord_d;
  logic [2:0] memwbWord_q, memwbWord_d;
  logic [0:0] state_q, state_d;
  logic [1:0] bubbleCnt_q, bubbleCnt_d;
  logic       illegal_q, illegal_d;

  logic [7:0] decWord;
  logic [1:0] decBranchSrc;
  logic [1:0] decCompare;
  logic       decJump;
  logic       decIllegal;
  logic       decUsesRt;
  logic       loadUse;
  logic       idActive;

  always_comb begin
    decWord      = 8'h00;
    decBranchSrc = 2'd0;
    decCompare   = 2'd0;
    decJump      = 1'b0;
    decIllegal   = 1'b0;
    decUsesRt    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        decUsesRt = 1'b1;
        if (funct == FN_JR) begin
          decJump      = 1'b1;
          decBranchSrc = 2'd2;
          decCompare   = 2'd3;
        end else begin
          decWord = 8'h84;
        end
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: decWord = 8'h24;
      OP_LW: decWord = 8'h35;
      OP_SW: begin
        decWord   = 8'h08;
        decUsesRt = 1'b1;
      end
      OP_BEQ: begin
        decCompare = 2'd1;
        decUsesRt  = 1'b1;
      end
      OP_BNE: begin
        decCompare = 2'd2;
        decUsesRt  = 1'b1;
      end
      OP_J: begin
        decJump      = 1'b1;
        decBranchSrc = 2'd1;
        decCompare   = 2'd3;
      end
      OP_JAL: begin
        decWord      = 8'h46;
        decJump      = 1'b1;
        decBranchSrc = 2'd1;
        decCompare   = 2'd3;
      end
      default: decIllegal = 1'b1;
    endcase
  end

`ifdef LOAD_USE_STALL_EN
  logic [REG_ADDR_W-1:0] rtEx_q, rtEx_d;

  // A load in EX whose destination feeds the instruction in ID; $zero never creates a hazard.
  always_comb begin
    loadUse = ~reset & id_valid & idexWord_q[4] & (rtEx_q != '0) &
              ((rtEx_q == rs_id) | (decUsesRt & (rtEx_q == rt_id)));
  end
`else
  logic unusedIdFields;

  assign loadUse        = 1'b0;
  assign unusedIdFields = ^{rs_id, rt_id, decUsesRt};
`endif

  assign idActive = id_valid & ~reset & (state_q == ST_IDLE) & ~loadUse;

  assign is_jump      = idActive & decJump;
  assign branch_src   = idActive ? decBranchSrc : 2'd0;
  assign compare_code = idActive ? decCompare : 2'd0;

  assign ex_ctrl    = reset ? 3'd0 : idexWord_q[7:5];
  assign mem_ctrl   = reset ? 2'd0 : exmemWord_q[4:3];
  assign wb_ctrl    = reset ? 3'd0 : memwbWord_q[2:0];
  assign illegal_op = reset ? 1'b0 : illegal_q;
  assign stall_if   = ~reset & (hold | loadUse);
  assign flush_if   = ~reset & ~hold & (state_q == ST_BUBBLE);

  // Priority below reset: hold freezes, then flush, load-use, bubble, normal advance.
  always_comb begin
    idexWord_d  = idexWord_q;
    exmemWord_d = exmemWord_q;
    memwbWord_d = memwbWord_q;
    state_d     = state_q;
    bubbleCnt_d = bubbleCnt_q;
    illegal_d   = illegal_q;
`ifdef LOAD_USE_STALL_EN
    rtEx_d      = rtEx_q;
`endif
    if (!hold) begin
      exmemWord_d = idexWord_q[4:0];
      memwbWord_d = exmemWord_q[2:0];
      if (flush) begin
        idexWord_d  = 8'h00;
        state_d     = ST_IDLE;
        bubbleCnt_d = 2'd0;
        illegal_d   = 1'b0;
`ifdef LOAD_USE_STALL_EN
        rtEx_d      = '0;
`endif
      end else if (loadUse) begin
        idexWord_d = 8'h00;
        illegal_d  = 1'b0;
`ifdef LOAD_USE_STALL_EN
        rtEx_d     = '0;
`endif
      end else if (state_q == ST_BUBBLE) begin
        idexWord_d = 8'h00;
        illegal_d  = 1'b0;
`ifdef LOAD_USE_STALL_EN
        rtEx_d     = '0;
`endif
        if (bubbleCnt_q == 2'd0) begin
          state_d = ST_IDLE;
        end else begin
          bubbleCnt_d = bubbleCnt_q - 2'd1;
        end
      end else begin
        idexWord_d = idActive ? decWord : 8'h00;
        illegal_d  = idActive & decIllegal;
`ifdef LOAD_USE_STALL_EN
        rtEx_d     = idActive ? rt_id : '0;
`endif
        if (is_jump) begin
          state_d     = ST_BUBBLE;
          bubbleCnt_d = BUBBLE_LOAD;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idexWord_q  <= 8'h00;
      exmemWord_q <= 5'd0;
      memwbWord_q <= 3'd0;
      state_q     <= ST_IDLE;
      bubbleCnt_q <= 2'd0;
      illegal_q   <= 1'b0;
`ifdef LOAD_USE_STALL_EN
      rtEx_q      <= '0;
`endif
    end else begin
      idexWord_q  <= idexWord_d;
      exmemWord_q <= exmemWord_d;
      memwbWord_q <= memwbWord_d;
      state_q     <= state_d;
      bubbleCnt_q <= bubbleCnt_d;
      illegal_q   <= illegal_d;
`ifdef LOAD_USE_STALL_EN
      rtEx_q      <= rtEx_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit: directed per-cycle vectors with hand-computed expected outputs.
module tb_pipe_control_unit;

  localparam int JB = 2;
  localparam int OP_R = 'h00, OP_J = 'h02, OP_JAL = 'h03, OP_ADDI = 'h08;
  localparam int OP_LW = 'h23, OP_SW = 'h2B, OP_BAD = 'h3F;
  localparam int FN_ADD = 'h20, FN_JR = 'h08;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       hold = 1'b0;
  logic       flush = 1'b0;
  logic       idValid = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic [4:0] rsId = '0;
  logic [4:0] rtId = '0;
  logic       isJump, stallIf, flushIf, illegalOp;
  logic [1:0] branchSrc, compareCode, memCtrl;
  logic [2:0] exCtrl, wbCtrl;

  logic [15:0] expQ[$];
  string       nameQ[$];
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  pipe_control_unit #(.JUMP_BUBBLES(JB), .REG_ADDR_W(5)) dut (
    .clock(clock), .reset(reset), .hold(hold), .flush(flush), .id_valid(idValid),
    .opcode(opcode), .funct(funct), .rs_id(rsId), .rt_id(rtId),
    .is_jump(isJump), .branch_src(branchSrc), .compare_code(compareCode),
    .ex_ctrl(exCtrl), .mem_ctrl(memCtrl), .wb_ctrl(wbCtrl),
    .stall_if(stallIf), .flush_if(flushIf), .illegal_op(illegalOp)
  );

  // Expected word: {is_jump, branch_src, compare_code, ex, mem, wb, stall_if, flush_if, illegal_op}
  function automatic logic [15:0] mkExp(input int j, input int bs, input int cc, input int ex,
                                        input int mem, input int wb, input int st, input int fl,
                                        input int il);
    return {j[0], bs[1:0], cc[1:0], ex[2:0], mem[1:0], wb[2:0], st[0], fl[0], il[0]};
  endfunction

  task automatic checkOutput(input string name, input string field, input logic [2:0] act,
                             input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=%0h required=%0h", name, field, act, exp);
    end
  endtask

  task automatic applyStimulus(input string name, input int rst, input int hd, input int fl,
                               input int v, input int op, input int fn, input int rs,
                               input int rt, input logic [15:0] exp);
    @(posedge clock);
    #1;
    reset   = rst[0];
    hold    = hd[0];
    flush   = fl[0];
    idValid = v[0];
    opcode  = op[5:0];
    funct   = fn[5:0];
    rsId    = rs[4:0];
    rtId    = rt[4:0];
    expQ.push_back(exp);
    nameQ.push_back(name);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle against the queued expectation.
  initial begin
    logic [15:0] e;
    string       n;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput(n, "is_jump",      3'(isJump),      3'(e[15]));
        checkOutput(n, "branch_src",   3'(branchSrc),   3'(e[14:13]));
        checkOutput(n, "compare_code", 3'(compareCode), 3'(e[12:11]));
        checkOutput(n, "ex_ctrl",      exCtrl,          e[10:8]);
        checkOutput(n, "mem_ctrl",     3'(memCtrl),     3'(e[7:6]));
        checkOutput(n, "wb_ctrl",      wbCtrl,          e[5:3]);
        checkOutput(n, "stall_if",     3'(stallIf),     3'(e[2]));
        checkOutput(n, "flush_if",     3'(flushIf),     3'(e[1]));
        checkOutput(n, "illegal_op",   3'(illegalOp),   3'(e[0]));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    $display("[TB] reset and straight-line decode");
    applyStimulus("rst_jal",   1,0,0,1, OP_JAL, 0, 0, 0,   mkExp(0,0,0,0,0,0,0,0,0));
    applyStimulus("addi",      0,0,0,1, OP_ADDI,0, 1, 2,   mkExp(0,0,0,0,0,0,0,0,0));
    applyStimulus("lw",        0,0,0,1, OP_LW,  0, 3, 4,   mkExp(0,0,0,1,0,0,0,0,0));
    applyStimulus("sw",        0,0,0,1, OP_SW,  0, 6, 7,   mkExp(0,0,0,1,0,0,0,0,0));
    applyStimulus("drain1",    0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,0,2,4,0,0,0));
    applyStimulus("drain2",    0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,0,1,5,0,0,0));
    applyStimulus("drain3",    0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,0,0,0,0,0,0));
    $display("[TB] jump bubbles");
    applyStimulus("jal",       0,0,0,1, OP_JAL, 0, 0, 0,   mkExp(1,1,3,0,0,0,0,0,0));
    applyStimulus("jal_bub1",  0,0,0,1, OP_ADDI,0, 1, 2,   mkExp(0,0,0,2,0,0,0,1,0));
    applyStimulus("jal_bub2",  0,0,0,1, OP_JAL, 0, 0, 0,   mkExp(0,0,0,0,0,0,0,1,0));
    applyStimulus("jal_wb",    0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,0,0,6,0,0,0));
    applyStimulus("jr",        0,0,0,1, OP_R,   FN_JR, 31, 0, mkExp(1,2,3,0,0,0,0,0,0));
    applyStimulus("jr_flush",  0,0,1,1, OP_ADDI,0, 1, 2,   mkExp(0,0,0,0,0,0,0,1,0));
    applyStimulus("post_flush",0,0,0,1, OP_R,   FN_ADD, 1, 2, mkExp(0,0,0,0,0,0,0,0,0));
    applyStimulus("j_flush",   0,0,1,1, OP_J,   0, 0, 0,   mkExp(1,1,3,4,0,0,0,0,0));
    applyStimulus("j_discard", 0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,0,0,0,0,0,0));
    applyStimulus("j_drain",   0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,0,0,4,0,0,0));
    $display("[TB] hold during a stream");
    applyStimulus("s_add",     0,0,0,1, OP_R,   FN_ADD, 1, 2, mkExp(0,0,0,0,0,0,0,0,0));
    applyStimulus("s_lw",      0,0,0,1, OP_LW,  0, 3, 4,   mkExp(0,0,0,4,0,0,0,0,0));
    applyStimulus("s_sw",      0,0,0,1, OP_SW,  0, 6, 7,   mkExp(0,0,0,1,0,0,0,0,0));
    for (int i = 0; i < 3; i++)
      applyStimulus("s_hold",  0,1,0,1, OP_R,   FN_ADD, 1, 2, mkExp(0,0,0,0,2,4,1,0,0));
    applyStimulus("s_resume",  0,0,0,1, OP_R,   FN_ADD, 1, 2, mkExp(0,0,0,0,2,4,0,0,0));
    applyStimulus("s_d1",      0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,4,1,5,0,0,0));
    applyStimulus("s_d2",      0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,0,0,0,0,0,0));
    applyStimulus("s_d3",      0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,0,0,4,0,0,0));
    $display("[TB] hold inside a bubble");
    applyStimulus("hb_jal",    0,0,0,1, OP_JAL, 0, 0, 0,   mkExp(1,1,3,0,0,0,0,0,0));
    applyStimulus("hb_hold",   0,1,0,1, OP_ADDI,0, 1, 2,   mkExp(0,0,0,2,0,0,1,0,0));
    applyStimulus("hb_bub1",   0,0,0,1, OP_ADDI,0, 1, 2,   mkExp(0,0,0,2,0,0,0,1,0));
    applyStimulus("hb_bub2",   0,0,0,1, OP_ADDI,0, 1, 2,   mkExp(0,0,0,0,0,0,0,1,0));
    applyStimulus("hb_idle",   0,0,0,1, OP_ADDI,0, 1, 2,   mkExp(0,0,0,0,0,6,0,0,0));
    applyStimulus("hb_d1",     0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,1,0,0,0,0,0));
    applyStimulus("hb_d2",     0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,0,0,0,0,0,0));
    $display("[TB] illegal opcode and reset mid-bubble");
    applyStimulus("bad_op",    0,0,0,1, OP_BAD, 0, 0, 0,   mkExp(0,0,0,0,0,4,0,0,0));
    applyStimulus("bad_flag",  0,0,0,1, OP_R,   FN_ADD, 1, 2, mkExp(0,0,0,0,0,0,0,0,1));
    applyStimulus("bad_inval", 0,0,0,0, OP_BAD, 0, 0, 0,   mkExp(0,0,0,4,0,0,0,0,0));
    applyStimulus("bad_clear", 0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,0,0,0,0,0,0));
    applyStimulus("rb_jal",    0,0,0,1, OP_JAL, 0, 0, 0,   mkExp(1,1,3,0,0,4,0,0,0));
    applyStimulus("rb_reset",  1,0,0,1, OP_R,   FN_ADD, 1, 2, mkExp(0,0,0,0,0,0,0,0,0));
    applyStimulus("rb_idle",   0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,0,0,0,0,0,0));
    $display("[TB] load-use sequences");
`ifdef LOAD_USE_STALL_EN
    applyStimulus("lu_lw",     0,0,0,1, OP_LW,  0, 1, 5,   mkExp(0,0,0,0,0,0,0,0,0));
    applyStimulus("lu_stall",  0,0,0,1, OP_R,   FN_ADD, 5, 2, mkExp(0,0,0,1,0,0,1,0,0));
    applyStimulus("lu_add",    0,0,0,1, OP_R,   FN_ADD, 5, 2, mkExp(0,0,0,0,2,0,0,0,0));
    applyStimulus("lu_d1",     0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,4,0,5,0,0,0));
    applyStimulus("lu0_lw",    0,0,0,1, OP_LW,  0, 1, 0,   mkExp(0,0,0,0,0,0,0,0,0));
    applyStimulus("lu0_add",   0,0,0,1, OP_R,   FN_ADD, 0, 0, mkExp(0,0,0,1,0,4,0,0,0));
    applyStimulus("lu0_d1",    0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,4,2,0,0,0,0));
    applyStimulus("lus_lw",    0,0,0,1, OP_LW,  0, 2, 6,   mkExp(0,0,0,0,0,5,0,0,0));
    applyStimulus("lus_stall", 0,0,0,1, OP_SW,  0, 1, 6,   mkExp(0,0,0,1,0,4,1,0,0));
    applyStimulus("lus_sw",    0,0,0,1, OP_SW,  0, 1, 6,   mkExp(0,0,0,0,2,0,0,0,0));
    applyStimulus("lus_d1",    0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,0,0,5,0,0,0));
`else
    applyStimulus("lu_lw",     0,0,0,1, OP_LW,  0, 1, 5,   mkExp(0,0,0,0,0,0,0,0,0));
    applyStimulus("lu_nostall",0,0,0,1, OP_R,   FN_ADD, 5, 2, mkExp(0,0,0,1,0,0,0,0,0));
    applyStimulus("lu_d1",     0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,4,2,0,0,0,0));
    applyStimulus("lu_d2",     0,0,0,0, 0,      0, 0, 0,   mkExp(0,0,0,0,0,5,0,0,0));
`endif
    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clock);
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_control_unit.md
# pipe_control_unit

Pipelined control unit for the mips32 core. It decodes `opcode`/`funct` in ID and carries the control word through the ID/EX, EX/MEM and MEM/WB control registers, so each stage sees its own slice. It supports stall, flush and a parametrised jump-bubble sequencer that holds fetch while a jump resolves. It replaces the purely combinational decoder at the ID stage and drives the datapath muxes, data memory enables and register-file write.

## Interface
Parameters:
- `JUMP_BUBBLES`, default 1: NOP cycles inserted after a jump. Legal range 1..3.
- `REG_ADDR_W`, default 5: register-address width.

Ports:
- `clock` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `hold` in 1: global freeze (memory wait). All control registers and the FSM keep their values.
- `flush` in 1: taken branch resolved. Clears the ID/EX control register and aborts the jump bubble.
- `id_valid` in 1: the IF/ID register holds a valid instruction.
- `opcode` in 6: opcode of the instruction in ID.
- `funct` in 6: function field of the instruction in ID.
- `rs_id` in REG_ADDR_W: rs field of the instruction in ID.
- `rt_id` in REG_ADDR_W: rt field of the instruction in ID.
- `is_jump` out 1: ID-stage output, J/JAL/JR decoded.
- `branch_src` out 2: ID-stage output. 0 = pc+4+imm, 1 = imm26, 2 = rs.
- `compare_code` out 2: ID-stage output. 0 = none, 1 = beq, 2 = bne, 3 = jump.
- `ex_ctrl` out 3: {AluSrc, RegDest[1:0]}.
- `mem_ctrl` out 2: {MemRead, MemWrite}.
- `wb_ctrl` out 3: {RegWrite, RegSrc[1:0]}.
- `stall_if` out 1: hold PC and IF/ID.
- `flush_if` out 1: replace the fetched instruction with a NOP.
- `illegal_op` out 1: registered; undecodable opcode seen in ID last cycle.

## Operation
- Control word is 8 bits: [7] AluSrc (1 = reg), [6:5] RegDest (0 rd, 1 rt, 2 $ra), [4] MemRead, [3] MemWrite, [2] RegWrite, [1:0] RegSrc (0 ALU, 1 mem, 2 pc+4).
- Opcode and funct values come from the codebase's `parameters.v`. Decode:
  - R-type (not JR): 0x84.
  - ADDI/ANDI/ORI/SLTI: 0x24.
  - LW: 0x35.
  - SW: 0x08.
  - BEQ/BNE: 0x00, branch_src 0, compare_code 1 or 2.
  - J: 0x00, branch_src 1, compare_code 3.
  - JAL: 0x46, branch_src 1, compare_code 3.
  - JR: 0x00, branch_src 2, compare_code 3.
  - Any other opcode: 0x00, and `illegal_op` is set for one cycle.
- ID outputs are combinational. They are forced to 0 when `id_valid`=0, `reset`, FSM in BUBBLE, or a load-use stall is active.
- Stage registers:
  - ID/EX captures the full 8-bit word.
  - EX/MEM captures bits [4:0].
  - MEM/WB captures bits [2:0].
- Update priority: `reset` > `hold` > `flush` > load-use > jump bubble > normal advance.
- Jump FSM:
  - IDLE → BUBBLE when `is_jump`=1 in IDLE; the counter loads `JUMP_BUBBLES`-1.
  - In BUBBLE: `flush_if`=1 and a NOP enters ID/EX each cycle; the counter decrements.
  - BUBBLE → IDLE when the counter is 0 or `flush`=1.
- `flush` with `hold`=0: ID/EX gets 0x00. EX/MEM and MEM/WB advance normally.

## Timing
- Every output is 0 during and after `reset`, and the FSM is IDLE.
- Latency from decode in ID:
  - `ex_ctrl`: +1 cycle.
  - `mem_ctrl`: +2 cycles.
  - `wb_ctrl`: +3 cycles.
  - `illegal_op`: +1 cycle.
- `hold`=1 freezes all registers, the FSM and the counter. `stall_if` is asserted and `flush_if`=0.
- A jump decoded on the same cycle as `flush` is discarded. The FSM stays IDLE.
- Reset mid-bubble or mid-stall returns to IDLE with all outputs 0 on the next edge.
- Back-to-back jumps cannot occur: the second jump is flushed by the bubble.

## Configuration
- Macro: `LOAD_USE_STALL_EN`.
- Defined:
  - If ID/EX holds MemRead=1 with rt_ex equal to `rs_id`, or equal to `rt_id` for R-type/BEQ/BNE/SW, with `id_valid`=1, then assert `stall_if` for exactly one cycle and insert 0x00 into ID/EX.
  - rt_ex is registered alongside ID/EX.
  - rt_ex = 0 never stalls.
- Undefined:
  - No rt_ex register is built and `stall_if` = `hold`.
  - Load-use hazards are the responsibility of the external hazard unit.

## Test plan
- Reset, then ADDI (opcode 0x08) with `id_valid`=1 → `ex_ctrl`=3'b001 at +1, `mem_ctrl`=0 at +2, `wb_ctrl`=3'b100 at +3.
- LW followed by SW → `mem_ctrl` sequence 2'b10 then 2'b01 on consecutive cycles; `wb_ctrl` for LW is 3'b101.
- JAL with `JUMP_BUBBLES`=2 → `flush_if` high for 2 cycles; ID/EX holds 0x46 then 0x00, 0x00; `wb_ctrl`=3'b110 at +3.
- JR with `flush` in the first bubble cycle → FSM back to IDLE next cycle and `flush_if` drops.
- With `LOAD_USE_STALL_EN`: LW rt=5, then ADD rs=5 → `stall_if`=1 for one cycle, one 0x00 bubble in EX, then ADD gives `ex_ctrl`=3'b100. LW rt=0, then ADD rs=0 → no stall.
- `hold`=1 for 3 cycles during an R-type stream → all outputs frozen; the stream resumes unchanged. Opcode 0x3F → `illegal_op`=1 for one cycle.
